// File: rtl/hold_period_monitor_if.sv
// hold_period_monitor_if: gate/toggle inputs and the per-period record port of the monitor
interface hold_period_monitor_if #(
  parameter int CNT_W = 8,
  parameter int FT_W  = 2
);
  logic             g_in;
  logic             f_in;
  logic             clr;
  logic             out_ready;
  logic             out_valid;
  logic [CNT_W-1:0] out_hi_len;
  logic [CNT_W-1:0] out_lo_len;
  logic [FT_W-1:0]  out_f_tog;
  logic             out_timeout;
  logic             drop_sticky;
  logic             busy;
  modport master (
    output g_in, f_in, clr, out_ready,
    input  out_valid, out_hi_len, out_lo_len, out_f_tog, out_timeout, drop_sticky, busy
  );
  modport slave (
    input  g_in, f_in, clr, out_ready,
    output out_valid, out_hi_len, out_lo_len, out_f_tog, out_timeout, drop_sticky, busy
  );
endinterface

// File: rtl/hold_period_monitor.sv
// hold_period_monitor: measures each g period (high/low length, f edges) and emits one record per period
module hold_period_monitor #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255,
  parameter int FT_W    = 2
) (
  input logic                 clk,
  input logic                 rst,
  hold_period_monitor_if.slave m
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);
  localparam logic [FT_W-1:0]  FT_ONE  = FT_W'(1);
  localparam logic [FT_W-1:0]  FT_MAX  = '1;
  state_t state_q, state_d;
  logic g_q, f_q, rise, f_edge, start, cap, cap_to, load, busy;
  logic [CNT_W-1:0] hi_q, hi_d, lo_q, lo_d, out_hi_q, out_lo_q;
  logic [FT_W-1:0] ft_q, ft_d, out_ft_q;
  logic valid_q, valid_d, to_q, drop_q, drop_d;
  assign rise   = m.g_in & ~g_q;
  assign f_edge = m.f_in ^ f_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  always_comb begin
    state_d = (state_q == IDLE) ? (rise ? HIGH : IDLE) :
              (state_q == HIGH) ? (m.g_in ? HIGH : LOW) :
              (state_q == LOW)  ? (m.g_in ? HIGH : (lo_q == TO_LIM) ? IDLE : LOW) : IDLE;
  end
  // In LOW, g_q is always 0, so g_in=1 there is a rise that closes the period.
  always_comb begin
    busy   = state_q != IDLE;
    cap    = (state_q == LOW) & (m.g_in | (lo_q == TO_LIM));
    cap_to = (state_q == LOW) & ~m.g_in & (lo_q == TO_LIM);
    start  = (state_d == HIGH) & (state_q != HIGH);
  end
  always_comb begin
    hi_d    = start ? CNT_ONE :
              (state_q == HIGH & m.g_in & hi_q != CNT_MAX) ? hi_q + CNT_ONE : hi_q;
    lo_d    = (state_q == HIGH & ~m.g_in) ? CNT_ONE :
              (state_q == LOW & ~m.g_in & lo_q != TO_LIM) ? lo_q + CNT_ONE : lo_q;
    ft_d    = start ? FT_W'(f_edge) :
              (busy & f_edge & ft_q != FT_MAX) ? ft_q + FT_ONE : ft_q;
    load    = cap & (~valid_q | m.out_ready);
    valid_d = load | (valid_q & ~m.out_ready);
    drop_d  = (cap & ~load) | (drop_q & ~m.clr);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      g_q      <= 1'b1;
      f_q      <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      ft_q     <= '0;
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
      out_hi_q <= '0;
      out_lo_q <= '0;
      out_ft_q <= '0;
      to_q     <= 1'b0;
    end else begin
      g_q     <= m.g_in;
      f_q     <= m.f_in;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ft_q    <= ft_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      if (load) begin
        out_hi_q <= hi_q;
        out_lo_q <= lo_q;
        out_ft_q <= ft_q;
        to_q     <= cap_to;
      end
    end
  assign m.out_valid   = valid_q;
  assign m.out_hi_len  = out_hi_q;
  assign m.out_lo_len  = out_lo_q;
  assign m.out_f_tog   = out_ft_q;
  assign m.out_timeout = to_q;
  assign m.drop_sticky = drop_q;
  assign m.busy        = busy;
endmodule
